pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/Falco_pkg.sv | 18 +
 rtl/pcgen_perf_cnt.sv | 19 +
 rtl/pc_gen.sv | 102 ++++++++++
 tb/tb_pc_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/Falco_pkg.sv
// Shared Falco front-end types: PC width, fetch stride and the pc_gen FSM states.
package Falco_pkg;
  localparam int XLEN_WIDTH = 32;
  typedef logic [XLEN_WIDTH-1:0] pc_t;

  localparam pc_t PC_FETCH_STRIDE = pc_t'(8);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } pcgen_state_e;

  // Fetch addresses are word aligned; low two bits of any target are dropped.
  function automatic pc_t align_pc(input pc_t a);
    return {a[XLEN_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/pcgen_perf_cnt.sv
// Saturating front-end event counters, built only with FALCO_PCGEN_PERF_CNT_EN.
module pcgen_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        btb_evt,
  input  logic        flush_evt,
  output logic [31:0] btb_cnt,
  output logic [31:0] flush_cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (btb_evt && btb_cnt != 32'hFFFF_FFFF)     btb_cnt   <= btb_cnt + 32'd1;
      if (flush_evt && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// Dual-issue fetch PC generator with trap/mispredict redirect and BTB steering.
// Optional perf counters compiled in with FALCO_PCGEN_PERF_CNT_EN.
module pc_gen
  import Falco_pkg::*;
#(
  parameter pc_t RESET_VECTOR = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic trap_redirect,
  input  pc_t  trap_target,
  input  logic branch_mispredict,
  input  pc_t  branch_correct_addr,
  input  logic instr0_btb_hit,
  input  pc_t  instr0_btb_target_addr,
  input  logic instr1_btb_hit,
  input  pc_t  instr1_btb_target_addr,
  output pc_t  IF_instr0_pc,
  output pc_t  IF_instr1_pc,
  output logic IF_instr0_valid,
  output logic IF_instr1_valid,
  output logic instr0_pred_taken,
  output logic instr1_pred_taken,
  output logic fetch_flush
`ifdef FALCO_PCGEN_PERF_CNT_EN
  ,
  output logic [31:0] perf_btb_redirect_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);
  pcgen_state_e state;
  pc_t  pc;
  logic v0_r, v1_r;
  logic redirect;
  pc_t  redirect_pc;
  pc_t  seq_pc;

  assign redirect    = trap_redirect | branch_mispredict;
  assign redirect_pc = trap_redirect ? align_pc(trap_target) : align_pc(branch_correct_addr);

  assign IF_instr0_pc      = pc;
  assign IF_instr1_pc      = pc + pc_t'(4);
  assign instr0_pred_taken = v0_r & instr0_btb_hit;
  assign instr1_pred_taken = v1_r & instr1_btb_hit & ~instr0_pred_taken;
  assign IF_instr0_valid   = v0_r;
  assign IF_instr1_valid   = v1_r & ~instr0_pred_taken;
  assign fetch_flush       = redirect & ~rst;

  always_comb begin
    seq_pc = pc + PC_FETCH_STRIDE;
    if (instr0_pred_taken)      seq_pc = align_pc(instr0_btb_target_addr);
    else if (instr1_pred_taken) seq_pc = align_pc(instr1_btb_target_addr);
  end

  // Leaving STALL with stall=0 consumes the held pair, so it advances like RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc    <= align_pc(RESET_VECTOR);
      v0_r  <= 1'b0;
      v1_r  <= 1'b0;
    end else if (redirect) begin
      state <= RUN;
      pc    <= redirect_pc;
      v0_r  <= 1'b1;
      v1_r  <= 1'b1;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          v0_r  <= 1'b1;
          v1_r  <= 1'b1;
        end
        RUN, STALL: begin
          if (stall) begin
            state <= STALL;
          end else begin
            state <= RUN;
            pc    <= seq_pc;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FALCO_PCGEN_PERF_CNT_EN
  logic btb_evt;
  assign btb_evt = (state == RUN) & ~rst & ~redirect & ~stall &
                   (instr0_pred_taken | instr1_pred_taken);

  pcgen_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .btb_evt   (btb_evt),
    .flush_evt (fetch_flush),
    .btb_cnt   (perf_btb_redirect_cnt),
    .flush_cnt (perf_redirect_cnt)
  );
`endif
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes expected outputs, a monitor pops and compares.
module tb_pc_gen;
  import Falco_pkg::*;

  localparam pc_t RV = 32'h100;

  logic clk = 1'b0;
  logic rst, stall, trap_redirect, branch_mispredict, h0, h1;
  pc_t  tt, ba, t0, t1;
  pc_t  pc0, pc1;
  logic v0, v1, p0, p1, fl;
`ifdef FALCO_PCGEN_PERF_CNT_EN
  logic [31:0] cnt_btb, cnt_fl;
`endif

  always #5 clk = ~clk;

  pc_gen #(.RESET_VECTOR(RV)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall                  (stall),
    .trap_redirect          (trap_redirect),
    .trap_target            (tt),
    .branch_mispredict      (branch_mispredict),
    .branch_correct_addr    (ba),
    .instr0_btb_hit         (h0),
    .instr0_btb_target_addr (t0),
    .instr1_btb_hit         (h1),
    .instr1_btb_target_addr (t1),
    .IF_instr0_pc           (pc0),
    .IF_instr1_pc           (pc1),
    .IF_instr0_valid        (v0),
    .IF_instr1_valid        (v1),
    .instr0_pred_taken      (p0),
    .instr1_pred_taken      (p1),
    .fetch_flush            (fl)
`ifdef FALCO_PCGEN_PERF_CNT_EN
    ,
    .perf_btb_redirect_cnt  (cnt_btb),
    .perf_redirect_cnt      (cnt_fl)
`endif
  );

  typedef struct {
    pc_t pc0, pc1;
    logic v0, v1, p0, p1, fl;
    logic [31:0] cb, cf;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: fetch address, whether the pair is live, and phase.
  pc_t m_pc = RV;
  bit  m_live = 1'b0;
  int  m_phase = 0;           // 0 = just out of reset, 1 = fetching, 2 = held by stall
  logic [31:0] m_cb = '0, m_cf = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit tr, input pc_t ttv,
                     input bit bm, input pc_t bav, input bit a0, input pc_t a0t,
                     input bit a1, input pc_t a1t);
    exp_t e;
    bit ep0, ep1, efl;
    @(negedge clk);
    rst = r; stall = s; trap_redirect = tr; tt = ttv; branch_mispredict = bm; ba = bav;
    h0 = a0; t0 = a0t; h1 = a1; t1 = a1t;
    ep0 = m_live && a0;
    ep1 = m_live && a1 && !ep0;
    efl = (tr || bm) && !r;
    e.pc0 = m_pc; e.pc1 = m_pc + 32'd4;
    e.v0 = m_live; e.v1 = m_live && !ep0;
    e.p0 = ep0; e.p1 = ep1; e.fl = efl;
    e.cb = m_cb; e.cf = m_cf;
    q.push_back(e);
    if (r) begin
      m_pc = RV; m_live = 0; m_phase = 0; m_cb = '0; m_cf = '0;
    end else begin
      if (efl && m_cf != 32'hFFFF_FFFF) m_cf = m_cf + 1;
      if (tr) begin
        m_pc = ttv & ~32'h3; m_live = 1; m_phase = 1;
      end else if (bm) begin
        m_pc = bav & ~32'h3; m_live = 1; m_phase = 1;
      end else if (m_phase == 0) begin
        m_live = 1; m_phase = 1;
      end else if (s) begin
        m_phase = 2;
      end else begin
        if (m_phase == 1 && (ep0 || ep1) && m_cb != 32'hFFFF_FFFF) m_cb = m_cb + 1;
        m_phase = 1;
        if (ep0)      m_pc = a0t & ~32'h3;
        else if (ep1) m_pc = a1t & ~32'h3;
        else          m_pc = m_pc + 32'd8;
      end
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic mispredict(input pc_t a);
    cyc(0, 0, 0, '0, 1, a, 0, '0, 0, '0);
  endtask

  // Monitor: every cycle the DUT presents a fetch pair; compare against the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc0", pc0, e.pc0);
        chk("pc1", pc1, e.pc1);
        chk("valid0", {31'd0, v0}, {31'd0, e.v0});
        chk("valid1", {31'd0, v1}, {31'd0, e.v1});
        chk("pred0", {31'd0, p0}, {31'd0, e.p0});
        chk("pred1", {31'd0, p1}, {31'd0, e.p1});
        chk("flush", {31'd0, fl}, {31'd0, e.fl});
`ifdef FALCO_PCGEN_PERF_CNT_EN
        chk("perf_btb", cnt_btb, e.cb);
        chk("perf_flush", cnt_fl, e.cf);
`endif
      end
    end
  end

  initial begin
    rst = 1; stall = 0; trap_redirect = 0; branch_mispredict = 0; h0 = 0; h1 = 0;
    tt = '0; ba = '0; t0 = '0; t1 = '0;
    repeat (2) @(negedge clk);
    // Reset hold and release: BOOT pair at RV, then live at RV, then RV+8.
    cyc(1, 0, 0, '0, 0, '0, 0, '0, 0, '0);
    cyc(1, 1, 1, 32'h44, 1, 32'h55, 1, 32'h66, 1, 32'h77);
    idle(); idle(); idle();
    // Slot-0 BTB hit at 0x200.
    mispredict(32'h200);
    cyc(0, 0, 0, '0, 0, '0, 1, 32'h400, 0, '0);
    idle();
    // Slot-1 BTB hit at 0x200.
    mispredict(32'h200);
    cyc(0, 0, 0, '0, 0, '0, 0, '0, 1, 32'h80);
    idle();
    // Stall at 0x300 for three cycles, mispredict in the second.
    mispredict(32'h300);
    cyc(0, 1, 0, '0, 0, '0, 1, 32'h900, 0, '0);
    cyc(0, 1, 0, '0, 1, 32'h500, 0, '0, 0, '0);
    cyc(0, 1, 0, '0, 0, '0, 0, '0, 1, 32'hA00);
    idle();
    // Trap and mispredict together; unaligned trap target.
    cyc(0, 0, 1, 32'h1003, 1, 32'h2000, 0, '0, 0, '0);
    idle();
    // Wrap at the top of the address space.
    mispredict(32'hFFFF_FFF8);
    idle(); idle();
    // Reset in the middle of a stall with a redirect pending.
    cyc(0, 1, 0, '0, 0, '0, 0, '0, 0, '0);
    cyc(1, 1, 0, '0, 1, 32'h700, 1, 32'h800, 0, '0);
    idle(); idle();
`ifdef FALCO_PCGEN_PERF_CNT_EN
    @(posedge clk); #1;
    force dut.u_perf.flush_cnt = 32'hFFFF_FFFE;
    force dut.u_perf.btb_cnt   = 32'hFFFF_FFFE;
    release dut.u_perf.flush_cnt;
    release dut.u_perf.btb_cnt;
    m_cf = 32'hFFFF_FFFE; m_cb = 32'hFFFF_FFFE;
    repeat (3) mispredict(32'h40);
    repeat (3) cyc(0, 0, 0, '0, 0, '0, 1, 32'h40, 0, '0);
    idle();
`endif
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 64) == 0, ($urandom % 4) == 0,
          ($urandom % 32) == 0, $urandom,
          ($urandom % 16) == 0, $urandom,
          ($urandom % 4) == 0, $urandom,
          ($urandom % 4) == 0, $urandom);
    end
    @(negedge clk);
    #5;
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
